// File: rtl/laser_hit_monitor_if.sv
// Bus bundle for the laser hit monitor: per-pixel/frame inputs and registered status outputs.
interface laser_hit_monitor_if;
  logic        frame_tick;
  logic        laser_on;
  logic        enemy_on;
  logic        shooting;
  logic        revive;
  logic [7:0]  hp;
  logic        hit;
  logic        flash;
  logic        dead;
  logic [1:0]  state;
  logic [15:0] hit_count;

  // Driver side (video timing / game logic)
  modport master (
    output frame_tick, laser_on, enemy_on, shooting, revive,
    input  hp, hit, flash, dead, state, hit_count
  );

  // Monitor side
  modport slave (
    input  frame_tick, laser_on, enemy_on, shooting, revive,
    output hp, hit, flash, dead, state, hit_count
  );
endinterface

// File: rtl/laser_hit_monitor.sv
// Laser/enemy hit monitor: latches per-frame sprite overlap, applies damage once per frame,
// and sequences the enemy through alive, invulnerable, dying and dead states.
module laser_hit_monitor #(
  parameter int unsigned HP_INIT       = 100,
  parameter int unsigned DAMAGE        = 1,
  parameter int unsigned INVULN_FRAMES = 8,
  parameter int unsigned DYING_FRAMES  = 32
) (
  input logic               clk,
  input logic               reset,
  laser_hit_monitor_if.slave bus
);

  localparam logic [1:0] StAlive  = 2'd0;
  localparam logic [1:0] StInvuln = 2'd1;
  localparam logic [1:0] StDying  = 2'd2;
  localparam logic [1:0] StDead   = 2'd3;

  localparam logic [7:0] HpInit       = 8'(HP_INIT);
  localparam logic [7:0] Damage       = 8'(DAMAGE);
  localparam logic [7:0] InvulnFrames = 8'(INVULN_FRAMES);
  localparam logic [7:0] DyingFrames  = 8'(DYING_FRAMES);

  logic [1:0]  state_q, state_d;
  logic [7:0]  hp_q, hp_d;
  logic [7:0]  counter_q, counter_d;
  logic        latch_q, latch_d;
  logic        hit_q, hit_d;
  logic        flash_q, flash_d;
  logic        dead_q, dead_d;
  logic [15:0] hit_count_q, hit_count_d;

  logic overlap;
  logic frame_ov;
  logic revive_taken;

  // Next-state: overlap latch, damage on frame_tick, frame counters and revive
  always_comb begin
    overlap      = bus.laser_on & bus.enemy_on & bus.shooting;
    frame_ov     = latch_q | overlap;
    state_d      = state_q;
    hp_d         = hp_q;
    counter_d    = counter_q;
    hit_d        = 1'b0;
    hit_count_d  = hit_count_q;
    revive_taken = 1'b0;

    case (state_q)
      StAlive: begin
        if (bus.frame_tick && frame_ov) begin
          hp_d  = (hp_q > Damage) ? hp_q - Damage : 8'd0;
          hit_d = 1'b1;
          if (hit_count_q != 16'hffff) hit_count_d = hit_count_q + 16'd1;
          if (hp_d == 8'd0) begin
            state_d   = StDying;
            counter_d = DyingFrames;
          end else begin
            state_d   = StInvuln;
            counter_d = InvulnFrames;
          end
        end
      end
      StInvuln: begin
        if (bus.frame_tick) begin
          if (counter_q <= 8'd1) state_d = StAlive;
          else                   counter_d = counter_q - 8'd1;
        end
      end
      StDying: begin
        if (bus.frame_tick) begin
          if (counter_q <= 8'd1) state_d = StDead;
          else                   counter_d = counter_q - 8'd1;
        end
      end
      StDead: begin
        // revive wins over a coincident frame_tick; frame_tick has no effect here anyway
        if (bus.revive) begin
          state_d      = StAlive;
          hp_d         = HpInit;
          counter_d    = 8'd0;
          revive_taken = 1'b1;
        end
      end
      default: state_d = StAlive;
    endcase

    // A frame (or a fresh life) always starts with a clean overlap latch
    latch_d = latch_q;
    if (bus.frame_tick || revive_taken) latch_d = 1'b0;
    else if (overlap)                   latch_d = 1'b1;

    flash_d = ((state_d == StInvuln) || (state_d == StDying)) ? counter_d[0] : 1'b0;
    dead_d  = (state_d == StDead);
  end

  // State and registered outputs, asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StAlive;
      hp_q        <= HpInit;
      counter_q   <= 8'd0;
      latch_q     <= 1'b0;
      hit_q       <= 1'b0;
      flash_q     <= 1'b0;
      dead_q      <= 1'b0;
      hit_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      counter_q   <= counter_d;
      latch_q     <= latch_d;
      hit_q       <= hit_d;
      flash_q     <= flash_d;
      dead_q      <= dead_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign bus.hp        = hp_q;
  assign bus.hit       = hit_q;
  assign bus.flash     = flash_q;
  assign bus.dead      = dead_q;
  assign bus.state     = state_q;
  assign bus.hit_count = hit_count_q;

endmodule

// File: tb/tb_laser_hit_monitor.sv
// Bench for laser_hit_monitor: two instances (default and HP_INIT=3/DAMAGE=5) share stimulus;
// a frame-level model is checked every cycle, plus literal spot checks.
module tb_laser_hit_monitor;

  typedef struct {
    int phase;  // 0 alive, 1 invulnerable, 2 dying, 3 dead
    int hp;
    int left;   // frames remaining in the timed phase
    bit seen;   // overlap seen so far in this frame
    int hits;
    bit pulse;
  } mdl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ft = 1'b0, las = 1'b0, ene = 1'b0, sht = 1'b0, rv = 1'b0;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  laser_hit_monitor_if if_a ();
  laser_hit_monitor_if if_b ();

  assign if_a.frame_tick = ft;
  assign if_a.laser_on   = las;
  assign if_a.enemy_on   = ene;
  assign if_a.shooting   = sht;
  assign if_a.revive     = rv;
  assign if_b.frame_tick = ft;
  assign if_b.laser_on   = las;
  assign if_b.enemy_on   = ene;
  assign if_b.shooting   = sht;
  assign if_b.revive     = rv;

  laser_hit_monitor dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  laser_hit_monitor #(
    .HP_INIT       (3),
    .DAMAGE        (5),
    .INVULN_FRAMES (8),
    .DYING_FRAMES  (32)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  function automatic mdl_t reset_m(int hp_init);
    mdl_t m;
    m.phase = 0; m.hp = hp_init; m.left = 0; m.seen = 1'b0; m.hits = 0; m.pulse = 1'b0;
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, int hp_init, int dmg, int inv, int dyn,
                                bit f, bit ov, bit r);
    mdl_t n = m;
    n.pulse = 1'b0;
    if (m.phase == 3 && r) begin
      n.phase = 0; n.hp = hp_init; n.seen = 1'b0;
      return n;
    end
    if (f) begin
      n.seen = 1'b0;
      if (m.phase == 0 && (m.seen || ov)) begin
        n.hp    = (m.hp > dmg) ? m.hp - dmg : 0;
        n.pulse = 1'b1;
        if (m.hits < 65535) n.hits = m.hits + 1;
        n.phase = (n.hp == 0) ? 2 : 1;
        n.left  = (n.hp == 0) ? dyn : inv;
      end else if (m.phase == 1 || m.phase == 2) begin
        if (m.left == 1) n.phase = (m.phase == 1) ? 0 : 3;
        else             n.left  = m.left - 1;
      end
    end else if (ov) begin
      n.seen = 1'b1;
    end
    return n;
  endfunction

  function automatic int exp_flash(mdl_t m);
    return (m.phase == 1 || m.phase == 2) ? (m.left % 2) : 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= reset_m(100);
      mb <= reset_m(3);
    end else begin
      ma <= step(ma, 100, 1, 8, 32, ft, las & ene & sht, rv);
      mb <= step(mb, 3, 5, 8, 32, ft, las & ene & sht, rv);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input logic [7:0] hp, input logic hit, input logic flash,
                     input logic dead, input logic [1:0] st, input logic [15:0] hc, input mdl_t m);
    check({tag, ".hp"},        32'(hp),    32'(m.hp));
    check({tag, ".hit"},       32'(hit),   32'(m.pulse));
    check({tag, ".flash"},     32'(flash), 32'(exp_flash(m)));
    check({tag, ".dead"},      32'(dead),  32'(m.phase == 3));
    check({tag, ".state"},     32'(st),    32'(m.phase));
    check({tag, ".hit_count"}, 32'(hc),    32'(m.hits));
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a", if_a.hp, if_a.hit, if_a.flash, if_a.dead, if_a.state, if_a.hit_count, ma);
      cmp("b", if_b.hp, if_b.hit, if_b.flash, if_b.dead, if_b.state, if_b.hit_count, mb);
    end
  end

  task automatic drive(input bit f, input bit l, input bit e, input bit s, input bit r);
    @(posedge clk);
    #2;
    ft = f; las = l; ene = e; sht = s; rv = r;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Seven pixel cycles then a frame_tick cycle
  task automatic frame(input bit mid_ov, input bit l, input bit e, input bit s, input bit tick_ov);
    for (int i = 0; i < 7; i++) begin
      if (mid_ov && i == 3) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      else                  drive(1'b0, l, e, s, 1'b0);
    end
    drive(1'b1, tick_ov, tick_ov, tick_ov, 1'b0);
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("reset_a_hp", 32'(if_a.hp), 100);
    check("reset_a_state", 32'(if_a.state), 0);
    check("reset_a_hit_count", 32'(if_a.hit_count), 0);
    check("reset_b_hp", 32'(if_b.hp), 3);
    reset = 1'b0;

    // One overlap pixel mid-frame
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("single_hit_pulse", 32'(if_a.hit), 1);
    check("single_hp", 32'(if_a.hp), 99);
    check("single_state", 32'(if_a.state), 1);
    check("single_hit_count", 32'(if_a.hit_count), 1);
    check("lethal_b_hp", 32'(if_b.hp), 0);
    check("lethal_b_state", 32'(if_b.state), 2);
    idle();
    check("single_hit_one_cycle", 32'(if_a.hit), 0);

    // Overlap every frame: frames 2..10
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("invuln_flash_after_tick", 32'(if_a.flash), 1);
    for (int k = 3; k <= 10; k++) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("repeat_hit_frame10", 32'(if_a.hit), 1);
    check("repeat_hp", 32'(if_a.hp), 98);
    check("repeat_hit_count", 32'(if_a.hit_count), 2);

    // Not shooting: no hit; overlap only on the tick cycle: hit
    idle_frames(8);
    idle();
    check("back_alive", 32'(if_a.state), 0);
    frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    check("no_shoot_hit", 32'(if_a.hit), 0);
    check("no_shoot_hp", 32'(if_a.hp), 98);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    check("tick_only_hit", 32'(if_a.hit), 1);
    check("tick_only_hp", 32'(if_a.hp), 97);

    // Revive outside DEAD is ignored
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    check("revive_invuln_state", 32'(if_a.state), 1);
    check("revive_invuln_hp", 32'(if_a.hp), 97);
    idle_frames(8);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    check("revive_alive_state", 32'(if_a.state), 0);
    check("revive_alive_hp", 32'(if_a.hp), 97);

    // Instance b reaches DEAD after 32 dying ticks, then revive coincident with frame_tick
    idle_frames(4);
    idle();
    check("dying_last_frame_state", 32'(if_b.state), 2);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("dead_state", 32'(if_b.state), 3);
    check("dead_flag", 32'(if_b.dead), 1);
    check("dead_hp", 32'(if_b.hp), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    check("revived_state", 32'(if_b.state), 0);
    check("revived_hp", 32'(if_b.hp), 3);
    check("revived_hit_count", 32'(if_b.hit_count), 1);

    // Reset in DYING with the overlap latch set
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("b_dying_again", 32'(if_b.state), 2);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    #3;
    reset = 1'b1;
    #1;
    check("rst_a_hp", 32'(if_a.hp), 100);
    check("rst_a_state", 32'(if_a.state), 0);
    check("rst_a_flash", 32'(if_a.flash), 0);
    check("rst_a_hit_count", 32'(if_a.hit_count), 0);
    check("rst_b_hp", 32'(if_b.hp), 3);
    check("rst_b_state", 32'(if_b.state), 0);
    check("rst_b_dead", 32'(if_b.dead), 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    idle();
    check("rst_no_hit_after", 32'(if_b.hit), 0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("rst_clean_frame_hp", 32'(if_b.hp), 3);
    check("rst_clean_frame_a_hp", 32'(if_a.hp), 100);

    // Reset right as a hit pulse appears
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ft = 1'b0; las = 1'b0; ene = 1'b0; sht = 1'b0; rv = 1'b0;
    #1;
    check("rst_hit_cleared", 32'(if_a.hit), 0);
    check("rst_hit_hp", 32'(if_a.hp), 100);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (3) idle();
    check("rst_hit_no_pulse", 32'(if_a.hit), 0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
